mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Control unit for the multicycle RV32I core: Moore main FSM plus ALU and immediate-source decoders.
//  Sequences fetch/decode/execute/mem/writeback over one shared ALU and one unified memory port.
//  Drives immsrc into the immediate extender and all mux selects and write strobes of the datapath.
//  Sits beside the datapath; op/funct come from the instruction register (stable after Fetch).
// PARAMETERS
//  none; all encodings come from riscv_pkg
// PORTS
//  clk         in   1  single clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  zero        in   1  ALU zero flag (current cycle)
//  immsrc      out  2  00 I, 01 S, 10 B, 11 J (to extender)
//  alusrca     out  2  00 PC, 01 OldPC, 10 rs1
//  alusrcb     out  2  00 rs2, 01 immext, 10 const 4
//  resultsrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  adrsrc      out  1  0 PC, 1 Result
//  alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  irwrite, pcwrite, regwrite, memwrite  out  1 each  write strobes
//  illegal     out  1  sticky illegal-instruction flag (0 when ILLEGAL_TRAP_EN undefined)
// BEHAVIOUR
//  State register only sequential element; all outputs combinational from state/op/funct/zero.
//  Reset low: state <= FETCH asynchronously; all four strobes forced 0 while reset low.
//  After release, first edge executes FETCH. Reset mid-instruction abandons it; no partial writes.
//  FETCH   : adrsrc0 irwrite1 srcA00 srcB10 aluop00 result10 pcupdate1        -> DECODE
//  DECODE  : srcA01 srcB01 aluop00 (precompute branch target)
//            lw/sw(0000011/0100011)->MEMADR, R(0110011)->EXECR, I(0010011)->EXECI, jal(1101111)->JAL, beq(1100011)->BEQ
//  MEMADR  : srcA10 srcB01 aluop00    -> lw: MEMREAD, sw: MEMWRITE
//  MEMREAD : result00 adrsrc1 -> MEMWB        MEMWB : result01 regwrite1 -> FETCH
//  MEMWRITE: result00 adrsrc1 memwrite1 -> FETCH
//  EXECR   : srcA10 srcB00 aluop10 -> ALUWB   EXECI : srcA10 srcB01 aluop10 -> ALUWB
//  ALUWB   : result00 regwrite1 -> FETCH
//  JAL     : srcA01 srcB10 aluop00 result00 pcupdate1 -> ALUWB
//  BEQ     : srcA10 srcB00 aluop01 result00 branch1 -> FETCH
//  Unlisted outputs are 0 in each state. pcwrite = pcupdate | (branch & zero).
//  Latency (cycles): lw 5, sw 4, R/I 4, jal 4, beq 3.
//  ALU decode: aluop00 add; 01 sub; 10 by funct3: 000 sub if {op[5],funct7b5}==11 else add,
//   010 slt, 110 or, 111 and, others add. Never X.
//  immsrc from op (all cycles): sw 01, beq 10, jal 11, everything else 00. Never X.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: DECODE with op outside the 6 supported, or R/I funct3 not in {000,010,110,111},
//   -> TRAP: all strobes 0, illegal=1, held until reset (reset clears illegal).
//  Undefined: same cases DECODE -> FETCH (executes as nop; PC already advanced); illegal tied 0; no TRAP state.
// STRUCTURE
//  riscv_pkg: opcode localparams, statetype_t enum (FETCH..BEQ, TRAP), immsrc/alusrc/resultsrc/alucontrol encodings.
//  Sub-module mc_mainfsm: state register + next-state + per-state outputs; ALU/imm decoders stay inline in mc_controller.
// TESTING
//  reset low mid-MEMWRITE -> memwrite 0 at once; after release first cycle FETCH, irwrite=1 pcwrite=1.
//  lw (op 0000011) -> states F,D,MA,MR,MWB; regwrite=1 only in cycle 5, result01, immsrc 00.
//  sw (0100011) -> memwrite=1 only in cycle 4, adrsrc1, immsrc 01, regwrite never 1.
//  beq zero=1 -> pcwrite=1 in cycle 3, alucontrol 001; zero=0 -> pcwrite 0; back to FETCH either way.
//  R sub (funct3 000, funct7b5 1) -> alucontrol 001 in EXECR; I addi with funct7b5=1 -> 000.
//  op 0000000: with ILLEGAL_TRAP_EN illegal=1 and no strobes until reset; without, 2-cycle nop, next FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and ALU controls.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
    } statetype_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic funct3_supported(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_mainfsm.sv
// Main Moore FSM of the multicycle controller: state register, next state and
// per-state datapath controls. ILLEGAL_TRAP_EN adds a sticky TRAP state.
module mc_mainfsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       supported,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [1:0] aluop,
    output logic       irwrite,
    output logic       pcupdate,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal
);

    statetype_t state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    if (!supported) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= TRAP;
`else
                        state <= FETCH;
`endif
                    end else begin
                        case (op)
                            OP_LOAD, OP_STORE: state <= MEMADR;
                            OP_RTYPE:          state <= EXECR;
                            OP_ITYPE:          state <= EXECI;
                            OP_JAL:            state <= JAL;
                            OP_BEQ:            state <= BEQ;
                            default:           state <= FETCH;
                        endcase
                    end
                end
                MEMADR:   state <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                JAL:      state <= ALUWB;
                BEQ:      state <= FETCH;
`ifdef ILLEGAL_TRAP_EN
                TRAP:     state <= TRAP;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        resultsrc = RES_ALUOUT;
        adrsrc    = 1'b0;
        aluop     = ALUOP_ADD;
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        case (state)
            FETCH: begin
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = 1'b1;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECR: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB:    regwrite = 1'b1;
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            BEQ: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
        // State is already FETCH during reset; mask strobes so nothing is written.
        if (!reset) begin
            irwrite  = 1'b0;
            pcupdate = 1'b0;
            branch   = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state == TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: main FSM plus inline ALU and immediate decoders.
// Define ILLEGAL_TRAP_EN to trap unsupported instructions instead of skipping them.
module mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal
);

    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       supported;

    mc_mainfsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .supported (supported),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .adrsrc    (adrsrc),
        .aluop     (aluop),
        .irwrite   (irwrite),
        .pcupdate  (pcupdate),
        .branch    (branch),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .illegal   (illegal)
    );

    assign pcwrite = pcupdate | (branch & zero);

    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_JAL, OP_BEQ: supported = 1'b1;
            OP_RTYPE, OP_ITYPE:                supported = funct3_supported(funct3);
            default:                           supported = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = ({op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:   alucontrol = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: immsrc = IMM_S;
            OP_BEQ:   immsrc = IMM_B;
            OP_JAL:   immsrc = IMM_J;
            default:  immsrc = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; output vector per cycle is
// {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol, irwrite, pcwrite, regwrite, memwrite}.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite, illegal;
    logic [15:0] outs;

    int nchk  = 0;
    int npass = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign outs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                   irwrite, pcwrite, regwrite, memwrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            npass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered while the DUT sits in FETCH; leaves it in the following FETCH.
    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int n,
                       input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            check($sformatf("%s_c%0d", tag, i + 1), 32'(outs), 32'(e[i]));
        end
        check($sformatf("%s_ill", tag), 32'(illegal), 32'd0);
        cyc();
        check($sformatf("%s_next", tag), 32'({irwrite, pcwrite}), 32'b11);
    endtask

    initial begin
        reset = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        check("rst_strobes", 32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_fetch", 32'({irwrite, pcwrite}), 32'b11);

        run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 5,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_01_00_0_000_0000, 16'b00_00_00_00_1_000_0000,
            16'b00_00_00_01_0_000_0010);
        run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 4,
            16'b01_00_10_10_0_000_1100, 16'b01_01_01_00_0_000_0000,
            16'b01_10_01_00_0_000_0000, 16'b01_00_00_00_1_000_0001, 16'b0);
        run("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3,
            16'b10_00_10_10_0_000_1100, 16'b10_01_01_00_0_000_0000,
            16'b10_10_00_00_0_001_0100, 16'b0, 16'b0);
        run("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3,
            16'b10_00_10_10_0_000_1100, 16'b10_01_01_00_0_000_0000,
            16'b10_10_00_00_0_001_0000, 16'b0, 16'b0);
        run("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_00_00_0_001_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_00_00_0_000_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("r_or", 7'b0110011, 3'b110, 1'b0, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_00_00_0_011_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_01_00_0_000_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_01_00_0_101_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 4,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b00_10_01_00_0_010_0000, 16'b00_00_00_00_0_000_0010, 16'b0);
        run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 4,
            16'b11_00_10_10_0_000_1100, 16'b11_01_01_00_0_000_0000,
            16'b11_01_10_00_0_000_0100, 16'b11_00_00_00_0_000_0010, 16'b0);

        // Reset in the middle of a store.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        cyc(); cyc(); cyc();
        check("mid_memwrite", 32'(memwrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_strobes", 32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_fetch", 32'(outs), 32'(16'b01_00_10_10_0_000_1100));
        cyc();
        check("mid_decode", 32'(outs), 32'(16'b01_01_01_00_0_000_0000));
        cyc(); cyc();
        check("mid_sw_again", 32'(outs), 32'(16'b01_00_00_00_1_000_0001));
        cyc();
        check("mid_fetch2", 32'({irwrite, pcwrite}), 32'b11);

`ifdef ILLEGAL_TRAP_EN
        op = 7'b0000000; funct3 = 3'b000;
        #1;
        check("trap_c1", 32'(outs), 32'(16'b00_00_10_10_0_000_1100));
        cyc();
        check("trap_c2", 32'(outs), 32'(16'b00_01_01_00_0_000_0000));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("trap_hold%0d", i), 32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
            check($sformatf("trap_ill%0d", i), 32'(illegal), 32'd1);
        end
        #1 reset = 1'b0;
        #1;
        check("trap_rst_clr", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("trap_rel_fetch", 32'({irwrite, pcwrite}), 32'b11);
`else
        run("nop_op0", 7'b0000000, 3'b000, 1'b0, 1'b0, 2,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b0, 16'b0, 16'b0);
        run("nop_sll", 7'b0110011, 3'b001, 1'b0, 1'b0, 2,
            16'b00_00_10_10_0_000_1100, 16'b00_01_01_00_0_000_0000,
            16'b0, 16'b0, 16'b0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
